// File: rtl/dct_sum_deskew_pkg.sv
// Shared DCT parameters and frame slicing helper
// for the sum deskew / frame-gather stage.
package dct_sum_deskew_pkg;

  localparam int W   = 8;
  localparam int N   = 8;
  localparam int LAT = 1;
  localparam int WW  = W + 1;
  localparam int FW  = N * WW;
  localparam int VD  = LAT + W;
  localparam int CW  = $clog2(N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fstate_t;

  // coefficient i lives at bits [i*WW +: WW]
  function automatic logic [FW-1:0] put_coef(
    input logic [FW-1:0] f,
    input logic [CW-1:0] i,
    input logic [WW-1:0] c
  );
    logic [FW-1:0] r;
    r = f;
    r[i*WW +: WW] = c;
    return r;
  endfunction

endpackage

// File: rtl/dct_sum_deskew_bit_deskew.sv
// Triangular delay line: bit k is delayed W-1-k cycles
// so a staircase word leaves fully aligned.
module bit_deskew #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W:0]   s,
  output logic [W:0]   a
);

  assign a[W]   = s[W];
  assign a[W-1] = s[W-1];

  for (genvar k = 0; k < W - 1; k++) begin : g_tap
    localparam int D = W - 1 - k;
    logic [D-1:0] sr;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sr <= '0;
      end else begin
        sr[0] <= s[k];
        for (int j = 1; j < D; j++) begin
          sr[j] <= sr[j-1];
        end
      end
    end

    assign a[k] = sr[D-1];
  end

endmodule

// File: rtl/dct_sum_deskew.sv
// Rebuilds parallel sum words from the skewed adder
// and gathers N of them into a handshaked frame.
module dct_sum_deskew
  import dct_sum_deskew_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W:0]    S,
  output logic          word_valid,
  output logic [W:0]    word_out,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic [FW-1:0] frame_data,
  output logic          overflow
);

  logic [VD-1:0] vp;
  logic [W:0]    aligned;
  logic [CW-1:0] wcnt;
  logic [FW-1:0] staging;
  logic [FW-1:0] stage_n;
  logic          done;
  logic          load;
  logic          ovf_set;
  fstate_t       state_q;
  fstate_t       state_d;

  bit_deskew #(.W(W)) u_deskew (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (S),
    .a     (aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vp <= '0;
    end else begin
      vp <= {vp[VD-2:0], in_valid};
    end
  end

  // capture the aligned word the cycle before its valid tail
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_out <= '0;
    end else if (vp[VD-2]) begin
      word_out <= aligned;
    end
  end

  assign word_valid = vp[VD-1];
  assign done       = word_valid && (wcnt == CW'(N - 1));
  assign stage_n    = put_coef(staging, wcnt, word_out);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt    <= '0;
      staging <= '0;
    end else if (word_valid) begin
      staging <= stage_n;
      wcnt    <= done ? '0 : wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (done) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (frame_ready) begin
          if (done) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end else if (done) begin
          ovf_set = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_data <= '0;
      overflow   <= 1'b0;
    end else begin
      if (load) begin
        frame_data <= stage_n;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  assign frame_valid = (state_q == FULL);

endmodule

// File: tb/tb_dct_sum_deskew.sv
// Scoreboard bench: a skewed-adder model feeds the DUT,
// a negedge monitor checks words and frames against queues.
module tb_dct_sum_deskew;
  import dct_sum_deskew_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          frame_ready = 1'b0;
  logic [W:0]    S;
  logic          word_valid;
  logic [W:0]    word_out;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic          overflow;

  logic [W:0]    cur_sum = '0;
  logic [W:0]    hist [W];

  int checks = 0;
  int passed = 0;

  logic [W:0]    word_q  [$];
  logic [FW-1:0] frame_q [$];

  always #5 clk = ~clk;

  dct_sum_deskew dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .S           (S),
    .word_valid  (word_valid),
    .word_out    (word_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .overflow    (overflow)
  );

  // adder model: hist[j] is the sum launched j+1 cycles ago
  always @(posedge clk) begin
    hist[0] <= in_valid ? cur_sum : 9'($urandom);
    for (int i = 1; i < W; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    S = '0;
    for (int k = 0; k < W; k++) S[k] = hist[LAT+k-1][k];
    S[W] = hist[LAT+W-2][W];
  end

  task automatic chk(input string name,
                     input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic cin,
                      input logic push,
                      input logic [W:0] exp);
    in_valid = 1'b1;
    cur_sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    if (push) word_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] base,
                            input logic push,
                            output logic [FW-1:0] f);
    f = '0;
    for (int i = 0; i < N; i++) begin
      send(base + W'(i), '0, 1'b0, 1'b1, {1'b0, base + W'(i)});
      f[i*WW +: WW] = {1'b0, base + W'(i)};
    end
    if (push) frame_q.push_back(f);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_word_valid",  FW'(word_valid),  '0);
    chk("rst_word_out",    FW'(word_out),    '0);
    chk("rst_frame_valid", FW'(frame_valid), '0);
    chk("rst_frame_data",  frame_data,       '0);
    chk("rst_overflow",    FW'(overflow),    '0);
    rst_n = 1'b1;
    tick();
  endtask

  logic fv_p  = 1'b0;
  logic acc_p = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (word_valid) begin
        if (word_q.size() != 0) begin
          chk("word", FW'(word_out), FW'(word_q.pop_front()));
        end else begin
          checks++;
          $display("FAIL word_unexpected: got %h expected none", word_out);
        end
      end
      if (frame_valid && (!fv_p || acc_p)) begin
        if (frame_q.size() != 0) begin
          chk("frame", frame_data, frame_q.pop_front());
        end else begin
          checks++;
          $display("FAIL frame_unexpected: got %h expected none", frame_data);
        end
      end
      fv_p  = frame_valid;
      acc_p = frame_valid && frame_ready;
    end
  end

  initial begin
    int n;
    int cnt;
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;

    do_reset();

    // single add and latency
    send(8'h35, 8'h12, 1'b0, 1'b1, 9'h047);
    n = 1;
    while (!word_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", FW'(n), FW'(9));

    // subtracts
    send(8'h12, ~8'h35, 1'b1, 1'b1, 9'h0DD);
    send(8'h35, ~8'h12, 1'b1, 1'b1, 9'h123);
    repeat (12) tick();
    do_reset();

    // full frame
    frame_ready = 1'b1;
    send_frame(8'h01, 1'b1, fa);
    cnt = 0;
    repeat (20) begin
      tick();
      if (frame_valid) cnt++;
    end
    chk("fv_cycles", FW'(cnt), FW'(1));
    chk("ovf_full", FW'(overflow), '0);

    // backpressure: B dropped
    frame_ready = 1'b0;
    send_frame(8'h10, 1'b1, fa);
    send_frame(8'h20, 1'b0, fb);
    repeat (12) tick();
    chk("bp_data", frame_data, fa);
    chk("bp_ovf", FW'(overflow), FW'(1));
    chk("bp_fv", FW'(frame_valid), FW'(1));
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    tick();
    chk("bp_drain", FW'(frame_valid), '0);
    do_reset();

    // accept and complete in the same cycle
    send_frame(8'h30, 1'b1, fa);
    repeat (12) tick();
    chk("sim_a_fv", FW'(frame_valid), FW'(1));
    send_frame(8'h40, 1'b1, fb);
    repeat (8) tick();
    chk("sim_b_last", FW'(word_valid), FW'(1));
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("sim_fv", FW'(frame_valid), FW'(1));
    chk("sim_data", frame_data, fb);
    chk("sim_ovf", FW'(overflow), '0);
    do_reset();

    // bubbles
    frame_ready = 1'b1;
    fa = '0;
    for (int i = 1; i <= N; i++) begin
      send(W'(i), '0, 1'b0, 1'b1, WW'(i));
      fa[(i-1)*WW +: WW] = WW'(i);
      if (i == 3) repeat (4) tick();
    end
    frame_q.push_back(fa);
    repeat (14) tick();
    chk("bub_ovf", FW'(overflow), '0);

    // reset mid-frame discards partial words
    for (int i = 0; i < 3; i++) send(8'hA0, '0, 1'b0, 1'b0, '0);
    do_reset();
    send_frame(8'h50, 1'b1, fa);

    n = 0;
    while ((word_q.size() + frame_q.size()) != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain", FW'(word_q.size() + frame_q.size()), '0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dct_sum_deskew.md
# dct_sum_deskew

Output realignment and frame-gather stage that sits directly downstream of the bit-skewed pipelined adder in the 1-D DCT datapath. The adder emits each result as a staircase: bit k of a word appears on its sum bus k cycles after bit 0, and the carry appears alongside bit 7. This block rebuilds full parallel words from that staircase, tags them with a valid flag, and gathers N consecutive words into one coefficient frame. The frame is handed on with a valid/ready handshake.

## Interface
- W, 8: operand width; the sum word is W+1 bits (carry in the MSB).
- N, 8: words per frame (DCT points).
- LAT, 1: cycles from `in_valid` to the arrival of bit 0 on `S[0]`.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  high in the cycle the adder is loaded with a new word's bit-0 slice.
- S  in  W+1  raw staircase sum bus from the adder; `S[W]` is the carry.
- word_valid  out  1  one-cycle pulse; `word_out` holds a complete word.
- word_out  out  W+1  deskewed sum word.
- frame_valid  out  1  frame bank holds an unconsumed frame.
- frame_ready  in  1  downstream accepts the frame.
- frame_data  out  N*(W+1)  coefficient i is at bits `[i*(W+1) +: W+1]`.
- overflow  out  1  sticky; a completed frame was dropped.

## Operation
- **Staircase convention.** For a word launched at cycle t0:
  - `S[k]` carries bit k at cycle t0+LAT+k, for k = 0..W-1.
  - `S[W]` carries the carry at t0+LAT+W-1, the same cycle as bit W-1.
- **Deskew.** Delay `S[k]` by W-1-k cycles, so all bits of a word align at t0+LAT+W-1. The carry needs no delay. The aligned word is registered into `word_out`.
- **Valid tracking.** `in_valid` passes through a shift register of depth LAT+W. Its tail drives `word_valid`. Words with no matching `in_valid` are never emitted.
- **Word counter.** `wcnt` runs 0..N-1.
  - On `word_valid`, write `word_out` into staging slot `wcnt` and increment.
  - When `wcnt = N-1`, the frame is complete and `wcnt` wraps to 0.
- **Frame handoff.** States are EMPTY and FULL, with `frame_valid` = FULL.
  - EMPTY, frame completes: copy staging to `frame_data` and go to FULL.
  - FULL, `frame_ready` high, no frame completing: go to EMPTY.
  - FULL, `frame_ready` high, frame completes in the same cycle: load the new frame and stay FULL.
  - FULL, `frame_ready` low, frame completes: drop the new frame, hold `frame_data`, set `overflow`.
- **Bubbles.** Gaps in `in_valid` hold `wcnt` and the staging contents. There is no timeout.
- **Arithmetic.** No arithmetic is performed; bits pass through unmodified. Sign interpretation belongs downstream.

## Timing
- `word_valid` and `word_out` are asserted at cycle t0+LAT+W: latency LAT+W cycles, which is 9 at the defaults.
- `frame_valid` rises one cycle after the `word_valid` of the N-th word.
- Throughput is one word per cycle with back-to-back `in_valid`.
- Reset values: every output is 0; `wcnt` = 0; valid pipe, deskew delay line and staging are cleared; state is EMPTY.
- Reset mid-operation: in-flight and partial-frame words are discarded. The first `in_valid` after `rst_n` rises starts slot 0.
- Only `rst_n` clears `overflow`.

## Structure
- W, N and LAT come from the shared DCT parameter header, along with the frame bit-slicing rule for `frame_data`.
- One sub-module, `bit_deskew`: the triangular delay line, parameterised by W, with no control inputs.
- Valid pipe, counter, staging and handoff FSM live in the top module.

## Test plan
- **Single add.** Drive the staircase for 0x35+0x12 with `in_valid` at t0. Expect `word_out` = 9'h047 with `word_valid` at t0+9.
- **Subtract.** Drive the staircase for 0x12 + ~0x35 + 1. Expect 9'h0DD with carry 0. Then drive 0x35 + ~0x12 + 1 and expect 9'h123.
- **Full frame.** Send eight back-to-back words 1..8 with `frame_ready` high. Expect `frame_valid` for exactly one cycle, `frame_data` coef0 = 1 … coef7 = 8, and `overflow` = 0.
- **Backpressure.** Hold `frame_ready` low and send two frames, A then B. Expect `frame_data` to stay at A, `overflow` = 1, and B to be lost.
- **Simultaneous accept and complete.** Raise `frame_ready` in the cycle frame B completes. Expect `frame_data` to become B, `frame_valid` to stay 1, and `overflow` to stay 0.
- **Bubbles and reset.** Send words 1,2,3, a 4-cycle gap, then 4..8. Expect one frame of 1..8. Separately, pulse `rst_n` low after 3 words; expect all outputs 0 and a fresh frame from the next 8 words.
